bcd_to_bin: RTL

//   Sequential BCD-to-binary converter (reverse double-dabble), the decode

---
 rtl/bcd_to_bin.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Flags overflow past BIN_WIDTH bits and forces a zero result when any input digit is invalid.
module bcd_to_bin #(
    parameter int unsigned NUM_DIGITS = 16,
    parameter int unsigned BIN_WIDTH  = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_num,
    output logic                    busy,
    output logic                    done,
    output logic [BIN_WIDTH-1:0]    bin_num,
    output logic                    overflow,
    output logic                    err_digit
);

    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

    state_e                 state_q, state_d;
    logic [BcdW-1:0]        bcd_q;
    logic [BIN_WIDTH-1:0]   bin_q;
    logic [CntW-1:0]        cnt_q;
    logic                   err_pend_q;
    logic                   done_q;
    logic [BIN_WIDTH-1:0]   bin_num_q;
    logic                   overflow_q;
    logic                   err_digit_q;

    logic [BcdW+BIN_WIDTH-1:0] shifted;
    logic [BcdW-1:0]           bcd_adj;
    logic                      bad_digit;

    // Shift right, then pull every digit that landed at >= 8 back down by 3.
    always_comb begin
        shifted = {bcd_q, bin_q} >> 1;
        bcd_adj = shifted[BcdW+BIN_WIDTH-1 -: BcdW];
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_num[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StConvert;
            StConvert: if (cnt_q == CntW'(BIN_WIDTH - 1)) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            bin_num_q   <= '0;
            overflow_q  <= 1'b0;
            err_digit_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bcd_q      <= bcd_num;
                        bin_q      <= '0;
                        cnt_q      <= '0;
                        err_pend_q <= bad_digit;
                    end
                end
                StConvert: begin
                    bcd_q <= bcd_adj;
                    bin_q <= shifted[BIN_WIDTH-1:0];
                    cnt_q <= cnt_q + CntW'(1);
                end
                StDone: begin
                    done_q <= 1'b1;
                    if (err_pend_q) begin
                        bin_num_q   <= '0;
                        overflow_q  <= 1'b0;
                        err_digit_q <= 1'b1;
                    end else begin
                        bin_num_q   <= bin_q;
                        overflow_q  <= (bcd_q != '0);
                        err_digit_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q != StIdle);
        done      = done_q;
        bin_num   = bin_num_q;
        overflow  = overflow_q;
        err_digit = err_digit_q;
    end

endmodule
